bus_handshake: RTL and testbench

CPU-side system bus cycle controller, directly downstream of the state-control unit. When the state-control unit enters a memory or I/O state, it raises `req`. This block then:
- requests the bus (`zg`),
- waits for the grant (`zw`),
- drives bus ownership (`zwzg`) to the address/data driver enables,
- collects the OK/EN/PE answer, or times out.

It returns `oken` to the state-control unit to advance its state machine, and raises `alarm` on a no-answer condition.

---
 rtl/bus_pkg.sv | 41 ++++
 rtl/sync2.sv | 29 ++
 rtl/bus_handshake.sv | 190 +++++++++++++++++++
 tb/tb_bus_handshake.sv | 260 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/bus_pkg.sv
// ---------------------------------------------------------------------------
// bus_pkg
// Shared definitions for the CPU-side bus cycle controller.
//   bus_state_t          : controller state encoding (IDLE, REQ, OWN, RESP, REL)
//   ANS_OK/ANS_EN/ANS_PE : bit positions of the answer vector; a higher index
//                          means a higher priority when answers coincide
//   BUS_TIMEOUT_DEFAULT  : default grant / answer timeout in clock cycles
//   ans_pick()           : reduces an answer vector to a single one-hot flag
// No ports (package).
// ---------------------------------------------------------------------------
package bus_pkg;

    typedef enum logic [2:0] {
        IDLE = 3'd0,
        REQ  = 3'd1,
        OWN  = 3'd2,
        RESP = 3'd3,
        REL  = 3'd4
    } bus_state_t;

    localparam int ANS_OK = 0;
    localparam int ANS_EN = 1;
    localparam int ANS_PE = 2;

    localparam int BUS_TIMEOUT_DEFAULT = 64;

    // Keep only the highest-priority answer: PE over EN over OK.
    function automatic logic [2:0] ans_pick(input logic [2:0] ans);
        logic [2:0] sel;
        sel = '0;
        if (ans[ANS_PE]) begin
            sel[ANS_PE] = 1'b1;
        end else if (ans[ANS_EN]) begin
            sel[ANS_EN] = 1'b1;
        end else if (ans[ANS_OK]) begin
            sel[ANS_OK] = 1'b1;
        end
        return sel;
    endfunction

endpackage

// File: rtl/sync2.sv
// ---------------------------------------------------------------------------
// sync2
// Two-flop synchronizer for a single asynchronous bus line.
//   clk   in  1  destination clock
//   rst_n in  1  asynchronous active-low reset, clears both flops to 0
//   d     in  1  asynchronous input
//   q     out 1  synchronized output, two clock edges behind d
// ---------------------------------------------------------------------------
module sync2 (
    input  logic clk,
    input  logic rst_n,
    input  logic d,
    output logic q
);

    logic meta_p0;

    // stage p0 captures the raw line, stage p1 resolves metastability
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            meta_p0 <= 1'b0;
            q       <= 1'b0;
        end else begin
            meta_p0 <= d;
            q       <= meta_p0;
        end
    end

endmodule

// File: rtl/bus_handshake.sv
// ---------------------------------------------------------------------------
// bus_handshake
// System bus cycle controller sitting behind the state-control unit. On req
// it requests the bus, waits for the grant, owns the bus while waiting for an
// OK / EN / PE answer, reports completion with a one-cycle oken pulse and
// flags a no-answer condition through alarm.
//
// Optional feature macro: BUS_PARITY_CHECK_EN
//   defined   : rpe is a valid answer and pe_r has top priority
//   undefined : rpe is ignored, pe_r stays 0 (a cycle answered only by rpe
//               times out)
//
// Parameters
//   TIMEOUT_CYCLES         cycles allowed for grant and, separately, answer
// Ports
//   __clk          in  1  system clock
//   clo_n          in  1  asynchronous active-low reset
//   req            in  1  bus cycle request, level, held until oken
//   is_io          in  1  cycle is IN/OU, sampled with req in IDLE
//   zw             in  1  bus grant (asynchronous)
//   rok, ren, rpe  in  1  bus answers OK / ENgaged / Parity (asynchronous)
//   zg             out 1  bus request
//   zwzg           out 1  bus owned, enables the bus drivers
//   oken           out 1  one-cycle pulse, cycle finished
//   ok_r,en_r,pe_r out 1  latched answer type, valid from oken to next cycle
//   alarm          out 1  latched timeout flag, cleared when next cycle starts
//   busy           out 1  controller is not idle
// ---------------------------------------------------------------------------
module bus_handshake
    import bus_pkg::*;
#(
    parameter int TIMEOUT_CYCLES = BUS_TIMEOUT_DEFAULT
) (
    input  logic __clk,
    input  logic clo_n,
    input  logic req,
    input  logic is_io,
    input  logic zw,
    input  logic rok,
    input  logic ren,
    input  logic rpe,
    output logic zg,
    output logic zwzg,
    output logic oken,
    output logic ok_r,
    output logic en_r,
    output logic pe_r,
    output logic alarm,
    output logic busy
);

    localparam int              CNT_W    = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT_CYCLES - 1);
    localparam logic [CNT_W-1:0] CNT_MAX  = CNT_W'(TIMEOUT_CYCLES);

    logic zw_s;
    logic rok_s;
    logic ren_s;
    logic rpe_s;
    logic pe_ans;

    bus_state_t       state;
    bus_state_t       state_nxt;
    logic [CNT_W-1:0] cnt;
    logic             io_q;
    logic             zg_q;
    logic [2:0]       ans_raw;
    logic [2:0]       ans_sel;
    logic             ans_any;
    logic             cnt_done;
    logic             quiet;

    // asynchronous bus lines -> __clk domain
    sync2 u_sync_zw  (.clk(__clk), .rst_n(clo_n), .d(zw),  .q(zw_s));
    sync2 u_sync_rok (.clk(__clk), .rst_n(clo_n), .d(rok), .q(rok_s));
    sync2 u_sync_ren (.clk(__clk), .rst_n(clo_n), .d(ren), .q(ren_s));
    sync2 u_sync_rpe (.clk(__clk), .rst_n(clo_n), .d(rpe), .q(rpe_s));

`ifdef BUS_PARITY_CHECK_EN
    assign pe_ans = rpe_s;
`else
    // Parity answer is not part of the protocol in this build.
    logic rpe_s_unused;
    assign rpe_s_unused = rpe_s;
    assign pe_ans       = 1'b0;
`endif

    // ENgaged is only a legal answer to an I/O cycle.
    always_comb begin
        ans_raw         = '0;
        ans_raw[ANS_OK] = rok_s;
        ans_raw[ANS_EN] = ren_s & io_q;
        ans_raw[ANS_PE] = pe_ans;
    end

    assign ans_sel  = ans_pick(ans_raw);
    assign ans_any  = |ans_raw;
    assign cnt_done = (cnt == CNT_LAST);

    // Four-phase release: every handshake line must be back low.
    assign quiet = !zw_s && !rok_s && !ren_s && !pe_ans && !req;

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE: begin
                if (req) begin
                    state_nxt = REQ;
                end
            end
            REQ: begin
                if (zw_s) begin
                    state_nxt = OWN;
                end else if (!req) begin
                    state_nxt = IDLE;
                end else if (cnt_done) begin
                    state_nxt = RESP;
                end
            end
            OWN: begin
                // an answer arriving on the last allowed cycle still wins
                if (ans_any || cnt_done) begin
                    state_nxt = RESP;
                end
            end
            RESP: begin
                state_nxt = REL;
            end
            REL: begin
                if (quiet) begin
                    state_nxt = IDLE;
                end
            end
            default: begin
                state_nxt = IDLE;
            end
        endcase
    end

    always_ff @(posedge __clk or negedge clo_n) begin
        if (!clo_n) begin
            state <= IDLE;
            cnt   <= '0;
            io_q  <= 1'b0;
            zg_q  <= 1'b0;
            ok_r  <= 1'b0;
            en_r  <= 1'b0;
            pe_r  <= 1'b0;
            alarm <= 1'b0;
        end else begin
            state <= state_nxt;

            // zg is registered so it rises one clock after REQ is entered
            // and drops together with zwzg when the cycle is answered.
            zg_q <= (state != IDLE) && ((state_nxt == REQ) || (state_nxt == OWN));

            // restart on every state change, saturate instead of wrapping
            if (state != state_nxt) begin
                cnt <= '0;
            end else if (cnt != CNT_MAX) begin
                cnt <= cnt + 1'b1;
            end

            if (state == IDLE && req) begin
                io_q  <= is_io;
                ok_r  <= 1'b0;
                en_r  <= 1'b0;
                pe_r  <= 1'b0;
                alarm <= 1'b0;
            end

            // flags are loaded on entry to RESP so they are valid with oken
            if (state_nxt == RESP) begin
                if (state == OWN && ans_any) begin
                    ok_r <= ans_sel[ANS_OK];
                    en_r <= ans_sel[ANS_EN];
                    pe_r <= ans_sel[ANS_PE];
                end else begin
                    alarm <= 1'b1;
                end
            end
        end
    end

    assign zg   = zg_q;
    assign zwzg = (state == OWN);
    assign oken = (state == RESP);
    assign busy = (state != IDLE);

endmodule

// File: tb/tb_bus_handshake.sv
// ---------------------------------------------------------------------------
// tb_bus_handshake
// Self-checking bench for bus_handshake (TIMEOUT_CYCLES = 16). A bus cycle is
// described by a few offsets relative to the cycle in which req is raised;
// the expected timeline is worked out from the protocol rules with plain
// arithmetic and compared every clock against the DUT outputs.
// ---------------------------------------------------------------------------
module tb_bus_handshake;

    localparam int T = 16;
`ifdef BUS_PARITY_CHECK_EN
    localparam bit PAR = 1'b1;
`else
    localparam bit PAR = 1'b0;
`endif

    logic clk = 1'b0;
    logic clo_n;
    logic req;
    logic is_io;
    logic zw;
    logic rok;
    logic ren;
    logic rpe;
    logic zg;
    logic zwzg;
    logic oken;
    logic ok_r;
    logic en_r;
    logic pe_r;
    logic alarm;
    logic busy;

    int n_chk  = 0;
    int n_fail = 0;

    // expected latched flags {alarm, pe_r, en_r, ok_r}
    logic [3:0] cur_flags = 4'b0000;

    wire [7:0] obs = {zg, zwzg, oken, busy, alarm, pe_r, en_r, ok_r};

    always #5 clk = ~clk;

    bus_handshake #(.TIMEOUT_CYCLES(T)) dut (
        .__clk (clk),
        .clo_n (clo_n),
        .req   (req),
        .is_io (is_io),
        .zw    (zw),
        .rok   (rok),
        .ren   (ren),
        .rpe   (rpe),
        .zg    (zg),
        .zwzg  (zwzg),
        .oken  (oken),
        .ok_r  (ok_r),
        .en_r  (en_r),
        .pe_r  (pe_r),
        .alarm (alarm),
        .busy  (busy)
    );

    typedef struct {
        string      name;
        bit         io;
        int         g;
        int         a;
        bit         aok;
        bit         aen;
        bit         ape;
        logic [3:0] exp;
    } vec_t;

    vec_t tbl[14];

    task automatic check(input string name, input logic [7:0] act, input logic [7:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: zg,zwzg,oken,busy,alarm,pe,en,ok got %b expected %b", name, act, exp);
        end
    endtask

    // Final flags of a finished cycle, straight from the answer rules.
    function automatic logic [3:0] ref_flags(input bit answered, input bit io,
                                             input bit aok, input bit aen, input bit ape);
        if (!answered)   return 4'b1000;
        if (ape && PAR)  return 4'b0100;
        if (aen && io)   return 4'b0010;
        if (aok)         return 4'b0001;
        return 4'b1000;
    endfunction

    // req is raised in cycle 0. zw rises in cycle g (-1: never), the answer
    // lines in cycle a (-1: never); drop >= 1 withdraws req in that cycle.
    task automatic run_txn(input string name, input bit io, input int g, input int a,
                           input bit aok, input bit aen, input bit ape, input int drop,
                           input bit use_tbl, input logic [3:0] tbl_flags);
        int         o;
        int         resp;
        int         rel;
        int         seen;
        bit         valid;
        bit         answered;
        bit         raised;
        logic [3:0] fin;
        logic [7:0] exp;
        bit         zg_e;
        bit         zwzg_e;
        bit         oken_e;
        bit         busy_e;

        valid    = aok || (aen && io) || (ape && PAR);
        o        = -1;
        resp     = -1;
        answered = 1'b0;
        if (drop >= 0) begin
            rel = drop + 1;
        end else begin
            // grant seen two clocks after zw; it must beat the REQ timeout
            if (g >= 0 && g + 2 <= T) o = g + 3;
            else                      resp = T + 1;
            if (o >= 0) begin
                seen = (a >= 0 && valid) ? ((a + 2 > o) ? a + 2 : o) : (1 << 20);
                if (seen <= o + T - 1) begin
                    resp     = seen + 1;
                    answered = 1'b1;
                end else begin
                    resp = o + T;
                end
            end
            raised = (g >= 0 && g <= resp) ||
                     (a >= 0 && a <= resp && (aok || aen || (ape && PAR)));
            rel = raised ? resp + 4 : resp + 2;
        end
        fin = use_tbl ? tbl_flags : ref_flags(answered, io, aok, aen, ape);

        for (int c = 0; c <= rel; c++) begin
            @(posedge clk);
            #1;
            is_io = (c == 0) ? io : ~io;
            req   = (drop >= 0) ? (c < drop) : (c <= resp);
            zw    = (g >= 0) && (c >= g) && (drop >= 0 || c <= resp);
            rok   = (a >= 0) && (c >= a) && (c <= resp) && aok;
            ren   = (a >= 0) && (c >= a) && (c <= resp) && aen;
            rpe   = (a >= 0) && (c >= a) && (c <= resp) && ape;
            @(negedge clk);
            if (c == 1)    cur_flags = 4'b0000;
            if (c == resp) cur_flags = fin;
            zg_e   = (c >= 2) && (c < ((drop >= 0) ? drop + 1 : resp));
            zwzg_e = (o >= 0) && (c >= o) && (c < resp);
            oken_e = (c == resp);
            busy_e = (c >= 1) && (c < rel);
            exp    = {zg_e, zwzg_e, oken_e, busy_e, cur_flags};
            check($sformatf("%s c%0d", name, c), obs, exp);
        end
    endtask

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        tbl[0]  = '{"mem_ok",        1'b0,  2,  7, 1'b1, 1'b0, 1'b0, 4'b0001};
        tbl[1]  = '{"io_en",         1'b1,  1,  4, 1'b0, 1'b1, 1'b0, 4'b0010};
        tbl[2]  = '{"mem_en_only",   1'b0,  1,  4, 1'b0, 1'b1, 1'b0, 4'b1000};
        tbl[3]  = '{"ok_and_pe",     1'b0,  2,  5, 1'b1, 1'b0, 1'b1, PAR ? 4'b0100 : 4'b0001};
        tbl[4]  = '{"pe_only",       1'b0,  1,  3, 1'b0, 1'b0, 1'b1, PAR ? 4'b0100 : 4'b1000};
        tbl[5]  = '{"own_timeout",   1'b0,  0, -1, 1'b0, 1'b0, 1'b0, 4'b1000};
        tbl[6]  = '{"req_timeout",   1'b0, -1, -1, 1'b0, 1'b0, 1'b0, 4'b1000};
        tbl[7]  = '{"io_en_ok",      1'b1,  0,  2, 1'b1, 1'b1, 1'b0, 4'b0010};
        tbl[8]  = '{"mem_en_ok",     1'b0,  0,  2, 1'b1, 1'b1, 1'b0, 4'b0001};
        tbl[9]  = '{"ans_at_limit",  1'b0,  0, 16, 1'b1, 1'b0, 1'b0, 4'b0001};
        tbl[10] = '{"ans_too_late",  1'b0,  0, 17, 1'b1, 1'b0, 1'b0, 4'b1000};
        tbl[11] = '{"grant_at_lim",  1'b1, 14, 16, 1'b0, 1'b1, 1'b0, 4'b0010};
        tbl[12] = '{"grant_late",    1'b0, 15, -1, 1'b0, 1'b0, 1'b0, 4'b1000};
        tbl[13] = '{"io_all",        1'b1,  3,  3, 1'b1, 1'b1, 1'b1, PAR ? 4'b0100 : 4'b0010};

        clo_n = 1'b0;
        req   = 1'b0;
        is_io = 1'b0;
        zw    = 1'b0;
        rok   = 1'b0;
        ren   = 1'b0;
        rpe   = 1'b0;

        repeat (2) @(posedge clk);
        @(negedge clk);
        check("reset", obs, 8'h00);
        @(posedge clk);
        #1;
        clo_n = 1'b1;

        for (int i = 0; i < 14; i++) begin
            run_txn(tbl[i].name, tbl[i].io, tbl[i].g, tbl[i].a,
                    tbl[i].aok, tbl[i].aen, tbl[i].ape, -1, 1'b1, tbl[i].exp);
        end

        // abort in REQ, then a stray grant while idle
        run_txn("abort", 1'b0, -1, -1, 1'b0, 1'b0, 1'b0, 3, 1'b1, 4'b0000);
        for (int c = 0; c < 6; c++) begin
            @(posedge clk);
            #1;
            zw = 1'b1;
            @(negedge clk);
            check($sformatf("late_zw c%0d", c), obs, {4'b0000, cur_flags});
        end
        @(posedge clk);
        #1;
        zw = 1'b0;
        repeat (4) @(posedge clk);

        // asynchronous reset while the bus is owned
        @(posedge clk);
        #1;
        req   = 1'b1;
        is_io = 1'b0;
        zw    = 1'b1;
        repeat (4) @(posedge clk);
        @(negedge clk);
        check("pre_rst_own", obs, 8'b1101_0000);
        #2;
        clo_n = 1'b0;
        #1;
        check("rst_async", obs, 8'h00);
        cur_flags = 4'b0000;
        req = 1'b0;
        zw  = 1'b0;
        @(posedge clk);
        #1;
        clo_n = 1'b1;
        for (int c = 0; c < 3; c++) begin
            @(negedge clk);
            check($sformatf("post_rst c%0d", c), obs, 8'h00);
        end
        run_txn("after_rst", 1'b0, 2, 7, 1'b1, 1'b0, 1'b0, -1, 1'b1, 4'b0001);

        for (int i = 0; i < 30; i++) begin
            bit io;
            bit aok;
            bit aen;
            bit ape;
            int g;
            int a;
            io  = 1'($urandom_range(0, 1));
            aok = 1'($urandom_range(0, 1));
            aen = 1'($urandom_range(0, 1));
            ape = 1'($urandom_range(0, 1));
            g   = int'($urandom_range(0, T));
            a   = ($urandom_range(0, 5) == 0) ? -1 : g + int'($urandom_range(0, T + 3));
            run_txn($sformatf("rand%0d", i), io, g, a, aok, aen, ape, -1, 1'b0, 4'b0000);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
